// File: rtl/pipelined_shifter_if.sv
// Shift unit handshake bundle: input op (valid/ready/data/amt/mode/tag)
// and result (valid/ready/data/zero/tag); master drives ops, slave is the unit.
interface pipelined_shifter_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_tag
  );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR), log2(WIDTH) stages + output reg.
// Ports: clk, rst_n (sync, active-low), bus (slave: op in, result out).
module pipelined_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_shifter_if.slave   bus
);
  localparam int LOG2W = $clog2(WIDTH);
  localparam logic [1:0] M_SLL = 2'd0;
  localparam logic [1:0] M_SRL = 2'd1;
  localparam logic [1:0] M_SRA = 2'd2;
  localparam logic [1:0] M_ROR = 2'd3;

  function automatic logic [WIDTH-1:0] shf(
    input logic [WIDTH-1:0] d,
    input int               s,
    input logic [1:0]       m,
    input logic             sg
  );
    logic [WIDTH-1:0] fill;
    fill = ~({WIDTH{1'b1}} >> s);
    shf  = d;
    unique case (1'b1)
      (m == M_SLL): shf = d << s;
      (m == M_SRL): shf = d >> s;
      (m == M_SRA): shf = (d >> s) | (sg ? fill : '0);
      (m == M_ROR): shf = (d >> s) | (d << (WIDTH - s));
      default:      shf = d;
    endcase
  endfunction

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_zero_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             stall;
  logic             adv;

  // The whole pipe freezes, bubbles included, while a result waits.
  assign stall        = out_valid_q && !bus.out_ready;
  assign adv          = !stall;
  assign bus.in_ready = rst_n && !stall;

  logic             over;
  logic             sign0;
  logic [LOG2W-1:0] amt0;
  logic [WIDTH-1:0] opnd0;

  // Over-shift is resolved up front: operand becomes the fill, amount 0.
  always_comb begin
    sign0 = bus.in_data[WIDTH-1];
    over  = (bus.in_amt >= AMT_W'(WIDTH)) && (bus.in_mode != M_ROR);
    amt0  = bus.in_amt[LOG2W-1:0];
    opnd0 = bus.in_data;
    if (over) begin
      amt0  = '0;
      opnd0 = (bus.in_mode == M_SRA) ? {WIDTH{sign0}} : '0;
    end
  end

  logic             s_vld  [LOG2W+1];
  logic [WIDTH-1:0] s_dat  [LOG2W+1];
  logic [LOG2W-1:0] s_amt  [LOG2W+1];
  logic [1:0]       s_mode [LOG2W+1];
  logic             s_sgn  [LOG2W+1];
  logic [TAG_W-1:0] s_tag  [LOG2W+1];

  assign s_vld[0]  = bus.in_valid && bus.in_ready;
  assign s_dat[0]  = opnd0;
  assign s_amt[0]  = amt0;
  assign s_mode[0] = bus.in_mode;
  assign s_sgn[0]  = sign0;
  assign s_tag[0]  = bus.in_tag;

  for (genvar k = 0; k < LOG2W; k++) begin : g_stg
    logic             vld_q;
    logic [WIDTH-1:0] dat_q;
    logic [LOG2W-1:0] amt_q;
    logic [1:0]       mode_q;
    logic             sgn_q;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        dat_q  <= '0;
        amt_q  <= '0;
        mode_q <= '0;
        sgn_q  <= 1'b0;
        tag_q  <= '0;
      end else if (adv) begin
        vld_q  <= s_vld[k];
        dat_q  <= s_amt[k][k]
                  ? shf(s_dat[k], 2 ** k, s_mode[k], s_sgn[k])
                  : s_dat[k];
        amt_q  <= s_amt[k];
        mode_q <= s_mode[k];
        sgn_q  <= s_sgn[k];
        tag_q  <= s_tag[k];
      end
    end

    assign s_vld[k+1]  = vld_q;
    assign s_dat[k+1]  = dat_q;
    assign s_amt[k+1]  = amt_q;
    assign s_mode[k+1] = mode_q;
    assign s_sgn[k+1]  = sgn_q;
    assign s_tag[k+1]  = tag_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
      out_tag_q   <= '0;
    end else if (adv) begin
      out_valid_q <= s_vld[LOG2W];
      out_data_q  <= s_dat[LOG2W];
      out_zero_q  <= (s_dat[LOG2W] == '0);
      out_tag_q   <= s_tag[LOG2W];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter at WIDTH=16.
// Scenarios: reset, modes, over-shift, identity, backpressure, mid-flight reset.
module tb_pipelined_shifter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  pipelined_shifter_if #(.WIDTH(16), .AMT_W(5), .TAG_W(4)) bus ();

  pipelined_shifter #(.WIDTH(16), .AMT_W(5), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic [4:0] a,
                       input logic [1:0] m, input logic [3:0] t);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_mode  = m;
    bus.in_tag   = t;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(16'hFFFF, 5'd1, 2'd0, 4'd5);
    repeat (2) begin
      tick();
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
        n_bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready);
      end
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
      end
      n_cmp++;
      if (bus.out_data !== 16'h0000 || bus.out_tag !== 4'h0) begin
        n_bad++;
        $display("FAIL rst_out: data %h tag %h want 0000/0", bus.out_data, bus.out_tag);
      end
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_bad++; $display("FAIL rst_no_output: got out_valid %b want 0", bus.out_valid);
      end
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_release_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_modes();
    logic [15:0] e [4] = '{16'h4210, 16'h0842, 16'hF842, 16'h1842};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(16'h8421, 5'd4, 2'(i), 4'(i));
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
        n_bad++; $display("FAIL modes_in_ready[%0d]: got %b want 1", i, bus.in_ready);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL modes_early: out_valid %b want 0 at 3 cycles", bus.out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e[i] || bus.out_tag !== 4'(i)) begin
        n_bad++;
        $display("FAIL modes[%0d]: got v%b %h tag %h want v1 %h tag %h",
                 i, bus.out_valid, bus.out_data, bus.out_tag, e[i], 4'(i));
      end
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL modes_tail: out_valid %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_overshift();
    logic [15:0] d [4] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001};
    logic [4:0]  a [4] = '{5'd20, 5'd16, 5'd31, 5'd17};
    logic [1:0]  m [4] = '{2'd2, 2'd2, 2'd0, 2'd3};
    logic [15:0] e [4] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h8000};
    logic        z [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(d[i], a[i], m[i], 4'(8 + i));
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e[i] ||
          bus.out_zero !== z[i] || bus.out_tag !== 4'(8 + i)) begin
        n_bad++;
        $display("FAIL overshift[%0d]: got v%b %h z%b tag %h want v1 %h z%b tag %h",
                 i, bus.out_valid, bus.out_data, bus.out_zero, bus.out_tag,
                 e[i], z[i], 4'(8 + i));
      end
    end
    tick();
  endtask

  task automatic test_identity();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(16'hA5A5, 5'd0, 2'(i), 4'(12 + i));
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hA5A5 ||
          bus.out_zero !== 1'b0 || bus.out_tag !== 4'(12 + i)) begin
        n_bad++;
        $display("FAIL identity[%0d]: got v%b %h z%b tag %h want v1 a5a5 z0 tag %h",
                 i, bus.out_valid, bus.out_data, bus.out_zero, bus.out_tag, 4'(12 + i));
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int rcv = 0;
    int hold = 0;
    int cyc = 0;
    bit seen = 1'b0;
    bit acc;
    logic [15:0] e;
    while (rcv < 6 && cyc < 80) begin
      if (sent < 6) drive(16'h0003, 5'(sent), 2'd0, 4'(sent));
      else bus.in_valid = 1'b0;
      if (bus.out_valid === 1'b1) seen = 1'b1;
      bus.out_ready = !(seen && hold < 5);
      #1;
      if (!bus.out_ready) begin
        hold++;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
            bus.out_data !== 16'h0003 || bus.out_tag !== 4'h0) begin
          n_bad++;
          $display("FAIL bp_hold[%0d]: rdy %b v%b %h tag %h want rdy0 v1 0003 tag 0",
                   hold, bus.in_ready, bus.out_valid, bus.out_data, bus.out_tag);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        e = 16'(16'h0003 << rcv);
        n_cmp++;
        if (bus.out_data !== e || bus.out_tag !== 4'(rcv)) begin
          n_bad++;
          $display("FAIL bp_result[%0d]: got %h tag %h want %h tag %h",
                   rcv, bus.out_data, bus.out_tag, e, 4'(rcv));
        end
        rcv++;
      end
      acc = bus.in_valid && (bus.in_ready === 1'b1);
      tick();
      if (acc) sent++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n_cmp++;
    if (rcv != 6 || sent != 6 || hold != 5) begin
      n_bad++;
      $display("FAIL bp_counts: rcv %0d sent %0d hold %0d want 6/6/5", rcv, sent, hold);
    end
    repeat (6) begin
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_bad++; $display("FAIL bp_duplicate: out_valid %b want 0", bus.out_valid);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(16'h0001, 5'd1, 2'd0, 4'(i + 1));
      tick();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (6) begin
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL midrst_flush: out_valid %b tag %h want 0", bus.out_valid, bus.out_tag);
      end
      tick();
    end
    drive(16'hF000, 5'd12, 2'd1, 4'd7);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL midrst_ready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    repeat (3) begin
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_bad++; $display("FAIL midrst_latency: early out_valid %b want 0", bus.out_valid);
      end
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h000F ||
        bus.out_zero !== 1'b0 || bus.out_tag !== 4'd7) begin
      n_bad++;
      $display("FAIL midrst_result: got v%b %h z%b tag %h want v1 000f z0 tag 7",
               bus.out_valid, bus.out_data, bus.out_zero, bus.out_tag);
    end
    tick();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_mode   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_modes();
    test_overshift();
    test_identity();
    test_backpressure();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
